// File: rtl/multicycle_controller.sv
// Multi-cycle instruction sequencer: latches an opcode into IR and steps it through
// FETCH/DECODE/EXEC/MEM/WB, with memory timeout, HALT and a saturating retire counter.
module multicycle_controller #(
   parameter int OPW         = 4,
   parameter int ALUW        = 3,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNTW        = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic            inst_valid,
   input  logic [OPW-1:0]  inst,
   input  logic            mem_ready,
   input  logic            zero,
   output logic [ALUW-1:0] ALUop,
   output logic            reg_write,
   output logic            set,
   output logic            bne,
   output logic            read_mem,
   output logic            write_mem,
   output logic            memToReg,
   output logic            bypass,
   output logic            slp,
   output logic            ir_load,
   output logic            pc_inc,
   output logic            pc_branch,
   output logic            busy,
   output logic            halted,
   output logic            err,
   output logic [CNTW-1:0] retired
);

   localparam int WCW = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
   } state_t;

   typedef enum logic [2:0] {
      OP_LW = 3'b000, OP_SW = 3'b001, OP_BNE = 3'b010, OP_ADD = 3'b011,
      OP_AND = 3'b100, OP_SHL = 3'b101, OP_MOV = 3'b110, OP_HALT = 3'b111
   } op_t;

   state_t         state, state_nxt;
   logic [OPW-1:0] ir;
   logic [WCW-1:0] wcnt;
   logic           retire;
   logic           is_set;
   op_t            op;

   assign is_set = ir[3];
   assign op     = op_t'(ir[2:0]);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         ir      <= '0;
         wcnt    <= '0;
         retired <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_FETCH && inst_valid)
            ir <= inst;
         // EXEC always precedes MEM, so clearing here gives a fresh count on MEM entry
         if (state == S_EXEC)
            wcnt <= '0;
         else if (state == S_MEM)
            wcnt <= wcnt + 1'b1;
         if (retire && retired != '1)
            retired <= retired + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      retire    = 1'b0;
      case (state)
         S_IDLE:   if (start) state_nxt = S_FETCH;
         S_FETCH:  if (inst_valid) state_nxt = S_DECODE;
         S_DECODE: begin
            if (is_set)
               state_nxt = S_WB;
            else if (op == OP_HALT) begin
               state_nxt = S_HALT;
               retire    = 1'b1;
            end else
               state_nxt = S_EXEC;
         end
         S_EXEC: begin
            case (op)
               OP_LW, OP_SW: state_nxt = S_MEM;
               OP_BNE: begin
                  state_nxt = S_FETCH;
                  retire    = 1'b1;
               end
               default: state_nxt = S_WB;
            endcase
         end
         S_MEM: begin
            // mem_ready on the last allowed cycle still completes the access
            if (mem_ready) begin
               if (op == OP_LW)
                  state_nxt = S_WB;
               else begin
                  state_nxt = S_FETCH;
                  retire    = 1'b1;
               end
            end else if (wcnt == WCW'(MEM_TIMEOUT - 1))
               state_nxt = S_ERR;
         end
         S_WB: begin
            state_nxt = S_FETCH;
            retire    = 1'b1;
         end
         default: state_nxt = state;
      endcase
   end

   // ir_load/pc_inc follow the fetch handshake and pc_branch the zero flag in EXEC
   always_comb begin
      ALUop     = '0;
      reg_write = 1'b0;
      set       = 1'b0;
      bne       = 1'b0;
      read_mem  = 1'b0;
      write_mem = 1'b0;
      memToReg  = 1'b0;
      bypass    = 1'b0;
      slp       = 1'b0;
      ir_load   = 1'b0;
      pc_inc    = 1'b0;
      pc_branch = 1'b0;
      busy      = !(state == S_IDLE || state == S_HALT || state == S_ERR);
      halted    = (state == S_HALT);
      err       = (state == S_ERR);
      case (state)
         S_FETCH: begin
            ir_load = inst_valid;
            pc_inc  = inst_valid;
         end
         S_EXEC: begin
            case (op)
               OP_BNE: begin
                  ALUop     = ALUW'(3'b001);
                  bne       = 1'b1;
                  pc_branch = !zero;
               end
               OP_AND:  ALUop = ALUW'(3'b010);
               OP_SHL:  ALUop = ALUW'(3'b011);
               default: ALUop = '0;
            endcase
         end
         S_MEM: begin
            read_mem  = (op == OP_LW);
            write_mem = (op == OP_SW);
         end
         S_WB: begin
            reg_write = 1'b1;
            set       = is_set;
            memToReg  = !is_set && op == OP_LW;
            bypass    = !is_set && op == OP_MOV;
            slp       = !is_set && op == OP_SHL;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: table of single instructions plus
// hand sequences for memory wait, timeout, HALT, saturation and async reset.
module tb_multicycle_controller;

   localparam int CNTW = 4;
   localparam int unsigned RMAX = 15;

   logic            clk, reset_n, start, inst_valid, mem_ready, zero;
   logic [3:0]      inst;
   logic [2:0]      ALUop;
   logic            reg_write, set, bne, read_mem, write_mem, memToReg, bypass, slp;
   logic            ir_load, pc_inc, pc_branch, busy, halted, err;
   logic [CNTW-1:0] retired;
   logic [16:0]     ctl;

   multicycle_controller #(.OPW(4), .ALUW(3), .MEM_TIMEOUT(15), .CNTW(CNTW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .inst_valid(inst_valid),
      .inst(inst), .mem_ready(mem_ready), .zero(zero), .ALUop(ALUop),
      .reg_write(reg_write), .set(set), .bne(bne), .read_mem(read_mem),
      .write_mem(write_mem), .memToReg(memToReg), .bypass(bypass), .slp(slp),
      .ir_load(ir_load), .pc_inc(pc_inc), .pc_branch(pc_branch), .busy(busy),
      .halted(halted), .err(err), .retired(retired)
   );

   assign ctl = {ALUop, reg_write, set, bne, read_mem, write_mem, memToReg, bypass,
                 slp, ir_load, pc_inc, pc_branch, busy, halted, err};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  inst;
      logic        zero;
      int unsigned cyc;
      int unsigned rw;
      logic [5:0]  flags;   // {set, memToReg, bypass, slp, bne, pc_branch}
      int unsigned rd;
      int unsigned wr;
      logic [2:0]  alu;
   } vec_t;

   vec_t        tbl [10];
   int unsigned n_pass, n_total, exp_ret;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic int unsigned sat_inc(input int unsigned v);
      return (v < RMAX) ? v + 1 : v;
   endfunction

   // Entered at a negedge while in FETCH; returns at the negedge of the next FETCH.
   task automatic run_vec(input vec_t v, input int idx);
      int unsigned cyc, rw, rd, wr;
      logic [5:0]  f;
      logic [2:0]  alu;
      bit          done;
      inst = v.inst; zero = v.zero; inst_valid = 1'b1; mem_ready = 1'b1;
      cyc = 1; rw = 0; rd = 0; wr = 0; f = '0; alu = '0; done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         if (ir_load) done = 1'b1;
         else begin
            cyc++;
            rw  += int'(reg_write);
            rd  += int'(read_mem);
            wr  += int'(write_mem);
            f   |= {set, memToReg, bypass, slp, bne, pc_branch};
            alu |= ALUop;
         end
      end
      chk($sformatf("v%0d_done", idx), 32'(done), 32'd1);
      chk($sformatf("v%0d_cycles", idx), cyc, v.cyc);
      chk($sformatf("v%0d_reg_write", idx), rw, v.rw);
      chk($sformatf("v%0d_flags", idx), 32'(f), 32'(v.flags));
      chk($sformatf("v%0d_read_mem", idx), rd, v.rd);
      chk($sformatf("v%0d_write_mem", idx), wr, v.wr);
      chk($sformatf("v%0d_aluop", idx), 32'(alu), 32'(v.alu));
      exp_ret = sat_inc(exp_ret);
      chk($sformatf("v%0d_retired", idx), 32'(retired), exp_ret);
   endtask

   task automatic do_reset_start(input logic [3:0] first);
      @(negedge clk);
      reset_n = 1'b0; start = 1'b0;
      @(negedge clk);
      reset_n = 1'b1; start = 1'b1; inst = first; inst_valid = 1'b1; mem_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      exp_ret = 0;
   endtask

   initial begin
      int unsigned cnt;
      bit          got;
      n_pass = 0; n_total = 0; exp_ret = 0;
      tbl[0] = '{4'b0011, 1'b0, 4, 1, 6'b000000, 0, 0, 3'b000};  // ADD
      tbl[1] = '{4'b0100, 1'b0, 4, 1, 6'b000000, 0, 0, 3'b010};  // AND
      tbl[2] = '{4'b0101, 1'b0, 4, 1, 6'b000100, 0, 0, 3'b011};  // SHL
      tbl[3] = '{4'b0110, 1'b0, 4, 1, 6'b001000, 0, 0, 3'b000};  // MOV
      tbl[4] = '{4'b1000, 1'b0, 3, 1, 6'b100000, 0, 0, 3'b000};  // SET
      tbl[5] = '{4'b1111, 1'b0, 3, 1, 6'b100000, 0, 0, 3'b000};  // SET, op bits ignored
      tbl[6] = '{4'b0010, 1'b0, 3, 0, 6'b000011, 0, 0, 3'b001};  // BNE taken
      tbl[7] = '{4'b0010, 1'b1, 3, 0, 6'b000010, 0, 0, 3'b001};  // BNE not taken
      tbl[8] = '{4'b0001, 1'b0, 4, 0, 6'b000000, 0, 1, 3'b000};  // SW
      tbl[9] = '{4'b0000, 1'b0, 5, 1, 6'b010000, 1, 0, 3'b000};  // LW

      reset_n = 1'b0; start = 1'b0; inst_valid = 1'b0; inst = '0; mem_ready = 1'b0; zero = 1'b0;
      #3;
      chk("reset_ctl", 32'(ctl), 32'd0);
      chk("reset_retired", 32'(retired), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle_ctl", 32'(ctl), 32'd0);
      start = 1'b1; inst_valid = 1'b1; inst = 4'b0011;
      @(negedge clk);
      start = 1'b0;
      chk("fetch_ir_load", 32'(ir_load), 32'd1);
      chk("fetch_pc_inc", 32'(pc_inc), 32'd1);
      chk("fetch_busy", 32'(busy), 32'd1);

      for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

      // LW with mem_ready arriving on the sixth MEM cycle
      inst = 4'b0000; mem_ready = 1'b0; cnt = 0; got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if (read_mem) begin
            cnt++;
            if (cnt == 6) mem_ready = 1'b1;
         end else if (reg_write) begin
            got = 1'b1;
            chk("lw_wait_memToReg", 32'(memToReg), 32'd1);
         end
      end
      chk("lw_wait_wb_seen", 32'(got), 32'd1);
      chk("lw_wait_read_cycles", cnt, 32'd6);
      @(negedge clk);
      chk("lw_wait_refetch", 32'(ir_load), 32'd1);
      exp_ret = sat_inc(exp_ret);
      chk("lw_wait_retired", 32'(retired), exp_ret);

      // SW with mem_ready exactly on the timeout boundary cycle
      inst = 4'b0001; mem_ready = 1'b0; cnt = 0; got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if (write_mem) begin
            cnt++;
            if (cnt == 15) mem_ready = 1'b1;
         end else if (ir_load || err) got = 1'b1;
      end
      chk("sw_edge_write_cycles", cnt, 32'd15);
      chk("sw_edge_no_err", 32'(err), 32'd0);
      chk("sw_edge_refetch", 32'(ir_load), 32'd1);
      exp_ret = sat_inc(exp_ret);
      chk("sw_edge_retired", 32'(retired), exp_ret);

      // push the counter into saturation
      for (int i = 0; i < 4; i++) run_vec(tbl[0], 20 + i);

      // SW with no mem_ready: timeout to ERR, sticky
      inst = 4'b0001; mem_ready = 1'b0; cnt = 0; got = 1'b0;
      for (int k = 0; k < 60 && !got; k++) begin
         @(negedge clk);
         if (write_mem) cnt++;
         if (err) got = 1'b1;
      end
      chk("timeout_err", 32'(err), 32'd1);
      chk("timeout_mem_cycles", cnt, 32'd15);
      chk("timeout_ctl", 32'(ctl), 32'd1);
      start = 1'b1; mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      chk("err_sticky_ctl", 32'(ctl), 32'd1);
      chk("err_retired", 32'(retired), exp_ret);

      // HALT after a fresh reset
      do_reset_start(4'b0111);
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         if (halted) got = 1'b1;
      end
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_busy", 32'(busy), 32'd0);
      chk("halt_retired", 32'(retired), 32'd1);
      start = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      chk("halt_sticky_ctl", 32'(ctl), 32'd2);

      // async reset in the middle of a stalled SW
      do_reset_start(4'b0011);
      run_vec(tbl[0], 30);
      inst = 4'b0001; mem_ready = 1'b0; got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         if (write_mem) got = 1'b1;
      end
      chk("mid_mem_reached", 32'(got), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_ctl", 32'(ctl), 32'd0);
      chk("async_reset_retired", 32'(retired), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("post_reset_idle", 32'(ctl), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
